// File: rtl/video_bus_arbiter_pkg.sv
// video_bus_arbiter_pkg: shared video constants, FSM state encoding and
// the arbitration priority helper used by the video RAM arbiter.
// No ports; imported by the arbiter, its interface and the frame counter.
package video_bus_arbiter_pkg;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 8;
    localparam int FRAME_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        SRC_DISP = 2'd0,
        SRC_G0   = 2'd1,
        SRC_G1   = 2'd2,
        SRC_NONE = 2'd3
    } arb_src_e;

    // Display always wins; game logic is only eligible during blanking, and
    // when both game requesters are pending the round-robin pointer decides
    // (rr=0 favours req[0]).
    function automatic arb_src_e pick_winner(
        input logic       disp_req,
        input logic [1:0] req,
        input logic       blank,
        input logic       rr
    );
        return disp_req          ? SRC_DISP :
               !blank            ? SRC_NONE :
               (req == 2'b11)    ? (rr ? SRC_G1 : SRC_G0) :
               req[0]            ? SRC_G0 :
               req[1]            ? SRC_G1 : SRC_NONE;
    endfunction

endpackage

// File: rtl/video_bus_arbiter_if.sv
// video_bus_arbiter_if: requester and RAM signals of the video bus arbiter.
// Display channel: disp_req, disp_addr -> disp_ack.
// Game channels:   req[1:0], addr_0/1, wdata_0/1, we_0/1 -> ack[1:0].
// Shared:          rdata (read data during any ack).
// RAM side:        mem_addr, mem_wdata, mem_we -> mem_rdata (1-cycle latency).
// master: requesters and RAM model; slave: the arbiter.
interface video_bus_arbiter_if
    import video_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_ack;
    logic [1:0]        req;
    logic [ADDR_W-1:0] addr_0;
    logic [ADDR_W-1:0] addr_1;
    logic [DATA_W-1:0] wdata_0;
    logic [DATA_W-1:0] wdata_1;
    logic              we_0;
    logic              we_1;
    logic [1:0]        ack;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr, req, addr_0, addr_1, wdata_0, wdata_1,
               we_0, we_1, mem_rdata,
        output disp_ack, ack, rdata, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output disp_req, disp_addr, req, addr_0, addr_1, wdata_0, wdata_1,
               we_0, we_1, mem_rdata,
        input  disp_ack, ack, rdata, mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/video_bus_arbiter_frame_counter.sv
// frame_counter: counts vblank rising edges and pulses frame_tick on each.
// Ports: clk, reset (sync, active-high), vblank in;
//        frame_tick (1-cycle pulse), frame_cnt (wrapping frame count) out.
module frame_counter
    import video_bus_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               vblank,
    output logic               frame_tick,
    output logic [FRAME_W-1:0] frame_cnt
);
    logic               vblank_q;
    logic               tick_q;
    logic [FRAME_W-1:0] cnt_q;
    logic [FRAME_W-1:0] cnt_d;
    logic               rise;

    assign rise  = vblank & ~vblank_q;
    assign cnt_d = cnt_q + FRAME_W'(rise);

    // History is loaded with the live vblank during reset so a high vblank
    // at reset release is not mistaken for a new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            vblank_q <= vblank;
            tick_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            vblank_q <= vblank;
            tick_q   <= rise;
            cnt_q    <= cnt_d;
        end
    end

    assign frame_tick = tick_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: rtl/video_bus_arbiter.sv
// video_bus_arbiter: shares one synchronous video RAM between the display
// fetcher and two game-logic requesters; every access is IDLE->ISSUE->WAIT.
// Ports: clk, reset (sync, active-high); hblank, vblank blanking flags;
//        bus (slave modport: requester handshakes and RAM controls);
//        frame_tick, frame_cnt from the embedded frame counter.
module video_bus_arbiter
    import video_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hblank,
    input  logic               vblank,
    video_bus_arbiter_if.slave bus,
    output logic               frame_tick,
    output logic [FRAME_W-1:0] frame_cnt
);
    arb_state_e        state_q, state_d;
    arb_src_e          src_q, src_d;
    arb_src_e          win;
    logic              rr_q, rr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              in_wait;

    assign win = pick_winner(bus.disp_req, bus.req, hblank | vblank, rr_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            src_q       <= SRC_NONE;
            rr_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            rr_q        <= rr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    // The RAM controls are registered at the IDLE sample edge so they are
    // stable for the whole ISSUE cycle; mem_we is a one-cycle strobe.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        rr_d        = rr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win != SRC_NONE) begin
                    state_d     = ST_ISSUE;
                    src_d       = win;
                    mem_addr_d  = (win == SRC_DISP) ? bus.disp_addr :
                                  (win == SRC_G0)   ? bus.addr_0 : bus.addr_1;
                    mem_wdata_d = (win == SRC_G0) ? bus.wdata_0 :
                                  (win == SRC_G1) ? bus.wdata_1 : mem_wdata_q;
                    mem_we_d    = (win == SRC_G0) ? bus.we_0 :
                                  ((win == SRC_G1) & bus.we_1);
                    rr_d        = (win == SRC_DISP) ? rr_q : (win == SRC_G0);
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Acks and read data are decoded from the WAIT state, which is exactly
    // the cycle the synchronous RAM presents the addressed word.
    assign in_wait       = (state_q == ST_WAIT);
    assign bus.disp_ack  = in_wait && (src_q == SRC_DISP);
    assign bus.ack       = {in_wait && (src_q == SRC_G1), in_wait && (src_q == SRC_G0)};
    assign bus.rdata     = in_wait ? bus.mem_rdata : '0;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;

    frame_counter u_frame_counter (
        .clk        (clk),
        .reset      (reset),
        .vblank     (vblank),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt)
    );

endmodule

// File: doc/video_bus_arbiter.md
VIDEO_BUS_ARBITER -- requirements
Module: video_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, video RAM address width.
REQ-002 Parameter DATA_W, default 8, video RAM data width.
REQ-003 Port clk  in  1  system clock; all logic on posedge clk.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port hblank, vblank  in  1 each  blanking flags from the sync generator.
REQ-006 Port disp_req  in  1  display fetch request; disp_addr  in  ADDR_W.
REQ-007 Port disp_ack  out  1  display access complete; rdata valid this cycle.
REQ-008 Port req  in  2  game-logic requests; req[i] is paired with addr_i (ADDR_W), wdata_i (DATA_W) and we_i (1).
REQ-009 Port ack  out  2  one-hot access-complete strobe per requester.
REQ-010 Port rdata  out  DATA_W  read data, valid while any ack or disp_ack is high.
REQ-011 Port mem_addr (ADDR_W), mem_wdata (DATA_W), mem_we (1)  out  registered RAM controls.
REQ-012 Port mem_rdata  in  DATA_W  synchronous RAM output, one cycle after mem_addr.
REQ-013 Port frame_tick  out  1  one-cycle pulse on the vblank rising edge; frame_cnt  out  8  frames since reset.

Function
REQ-014 The FSM SHALL have three states: IDLE, ISSUE and WAIT; every access is IDLE->ISSUE->WAIT->IDLE, one cycle per state.
REQ-015 In IDLE, the arbiter SHALL sample requests and select at most one winner; with no request, it SHALL stay in IDLE.
REQ-016 When active display holds (hblank=0 and vblank=0), only disp_req SHALL be eligible; req[1:0] SHALL wait.
REQ-017 During blanking, disp_req SHALL still win; otherwise req[0]/req[1] SHALL be served round-robin, with the pointer toggling after each game-logic grant and favouring req[0] after reset.
REQ-018 In ISSUE, mem_addr/mem_we/mem_wdata SHALL carry the winner's values; the display channel SHALL always read (mem_we=0); mem_we SHALL be 0 in all other states.
REQ-019 In WAIT, rdata SHALL equal mem_rdata, and exactly one of disp_ack/ack[i] SHALL be high for that single cycle.
REQ-020 Total latency SHALL be 3 cycles, from the IDLE sample edge to the ack cycle; peak throughput SHALL be one access per 3 cycles.
REQ-021 Requesters SHALL hold req, addr, wdata and we stable until ack; they SHALL deassert req at the edge that ends the ack cycle, so IDLE never re-grants a completed request.
REQ-022 When blanking ends during ISSUE or WAIT, the in-flight access SHALL complete normally; the new eligibility rule applies from the next IDLE.
REQ-023 A req[i] that drops before grant SHALL be ignored; after grant, the access SHALL complete regardless.
REQ-024 frame_cnt SHALL increment on each vblank 0->1 transition, wrapping 255->0; frame_tick SHALL be high in the same cycle as the increment.
REQ-025 A transition SHALL be detected against a registered copy of vblank; the first cycle after reset SHALL NOT generate frame_tick, even when vblank=1.

Reset
REQ-026 Reset SHALL force state=IDLE, round-robin pointer=req[0], ack=0, disp_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, frame_cnt=0, frame_tick=0, and the vblank history register to the current vblank.
REQ-027 Reset asserted in ISSUE or WAIT SHALL abort the access with no ack issued; reset SHALL have priority over all other events.

Structure
REQ-028 A shared video package SHALL hold the FSM state encoding and the default ADDR_W/DATA_W constants, reused by the sync generator and future video blocks.
REQ-029 The frame counter and edge detector SHALL be a separate sub-module, frame_counter (inputs clk, reset, vblank; outputs frame_tick, frame_cnt); the arbiter SHALL instantiate it once.

Verification
REQ-030 Active display, req[0]=1 and disp_req=1 (disp_addr=0x0010): disp_ack SHALL fire 3 cycles later with rdata=RAM[0x10]; ack[0] SHALL NOT fire until blanking.
REQ-031 hblank=1, req=2'b11, both held: acks SHALL alternate ack[0], ack[1], ack[0], one every 3 cycles.
REQ-032 hblank=1, req[1] write addr_1=0x1234 with wdata_1=0xA5, then req[0] read 0x1234: ack[0] rdata SHALL be 0xA5.
REQ-033 hblank falls during ISSUE of a req[0] access: ack[0] SHALL still fire in the next cycle; then only disp_req SHALL be granted.
REQ-034 Reset asserted in WAIT: next cycle state=IDLE, all acks 0, mem_we=0; 256 vblank rising edges after reset SHALL leave frame_cnt=0 with 256 frame_tick pulses.
